// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        BOOT,
        RUN
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: shift-register FIFO whose head is always entry 0, so the
// head outputs come straight from flops.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [CW-1:0]            count_q, count_d;
    logic [CW-1:0]            wr_idx;

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        wr_idx  = pop ? count_q - CW'(1) : count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            if (pop) begin
                for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                    mem_d[i] = mem_q[i+1];
                end
            end
            // Write after the shift so a simultaneous pop frees the slot first.
            if (push) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == wr_idx) begin
                        mem_d[i] = push_data;
                    end
                end
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[0];

    overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !flush && count_q == CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential prefetch into a small queue, flushed on redirect.
// Optional fetch_count handshake counter is built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
`ifdef FETCH_PERF_CNT_EN
    output logic [XLEN-1:0] fetch_count,
`endif
    output logic [XLEN-1:0] instr_pc
);

    localparam int unsigned CW       = $clog2(QDEPTH + 1);
    localparam logic [CW:0] QDEPTH_W = (CW+1)'(QDEPTH);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic [CW-1:0]   q_count;
    fetch_entry_t    q_head;
    fetch_entry_t    push_entry;
    logic            pop, push, flush, issue;
    logic [CW:0]     occupancy;

    assign pop = instr_valid & instr_ready;
    // Slots already spoken for: queued words plus the response still on its way.
    assign occupancy = {1'b0, q_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);

    always_comb begin
        state_d    = RUN;
        issue      = (state_q == RUN) && !redirect && (occupancy < QDEPTH_W);
        push       = inflight_q && !redirect;
        flush      = (state_q == RUN) && redirect;
        inflight_d = issue;
        req_pc_d   = issue ? fetch_pc_q : req_pc_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = align_pc(redirect_pc);
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        push_entry = '{pc: req_pc_q, instr: imem_rdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush),
        .count     (q_count),
        .head      (q_head)
    );

    assign imem_req    = issue;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (q_count != '0);
    assign instr       = q_head.instr;
    assign instr_pc    = q_head.pc;

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + XLEN'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// ready/redirect traffic checked against a stream-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count (fetch_count),
`endif
        .instr_pc    (instr_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ROM: word i holds i.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    // Memory answers exactly one cycle after a request; garbage otherwise.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? rom(imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: program-order stream of expected pcs and requests.
    logic [31:0] m_req_pc, m_exp_pc, m_hs;
    logic [31:0] prev_pc, prev_instr;
    logic        m_req_prev, prev_stall, pop_s, exp_req;
    int          m_out, since_rst, since_redir;

    always @(negedge clk) begin
        if (rst) begin
            m_req_pc    = RESET_PC;
            m_exp_pc    = RESET_PC;
            m_hs        = '0;
            m_out       = 0;
            m_req_prev  = 1'b0;
            prev_stall  = 1'b0;
            since_rst   = 0;
            since_redir = 1000;
        end else begin
            pop_s   = instr_valid && instr_ready;
            exp_req = (since_rst > 0) && !redirect && ((m_out - (pop_s ? 1 : 0)) < QDEPTH);
            check("imem_req", 32'(imem_req), 32'(exp_req));
            check("instr_valid", 32'(instr_valid), 32'((m_out - (m_req_prev ? 1 : 0)) > 0));
            check("addr_align", 32'(imem_addr[1:0]), 32'd0);
            if (since_rst <= 2) check("boot_valid", 32'(instr_valid), 32'd0);
            if (since_redir == 1 || since_redir == 2) check("redir_gap", 32'(instr_valid), 32'd0);
            if (since_redir == 3) check("redir_latency", 32'(instr_valid), 32'd1);
            if (prev_stall) begin
                check("hold_valid", 32'(instr_valid), 32'd1);
                check("hold_pc", instr_pc, prev_pc);
                check("hold_instr", instr, prev_instr);
            end
`ifdef FETCH_PERF_CNT_EN
            check("fetch_count", fetch_count, m_hs);
`endif
            if (imem_req) begin
                check("req_addr", imem_addr, m_req_pc);
                m_req_pc = m_req_pc + 32'd4;
            end
            if (pop_s) begin
                check("instr_pc", instr_pc, m_exp_pc);
                check("instr", instr, rom(m_exp_pc));
                m_exp_pc = m_exp_pc + 32'd4;
                m_hs     = m_hs + 32'd1;
            end
            m_out = m_out + (imem_req ? 1 : 0) - (pop_s ? 1 : 0);
            if (redirect) begin
                m_req_pc = redirect_pc & 32'hFFFF_FFFC;
                m_exp_pc = redirect_pc & 32'hFFFF_FFFC;
                m_out    = 0;
            end
            m_req_prev  = imem_req && !redirect;
            prev_stall  = instr_valid && !instr_ready && !redirect;
            prev_pc     = instr_pc;
            prev_instr  = instr;
            if (redirect && since_rst > 0) since_redir = 1;
            else if (since_redir < 1000) since_redir++;
            if (since_rst < 1000) since_rst++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle, checks reset outputs, releases, and returns in cycle 1.
    task automatic do_reset(input logic boot_redir, input logic [31:0] boot_pc);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_fetch_count", fetch_count, 32'd0);
`endif
        tick();
        tick();
        rst         = 1'b0;
        redirect    = boot_redir;
        redirect_pc = boot_pc;
        tick();
        redirect    = 1'b0;
    endtask

    logic [31:0] hold_pc, hold_instr;
    int          hs;
    logic        redir_done;

    initial begin
        // Reset release, back-to-back delivery from RESET_PC.
        instr_ready = 1'b1;
        do_reset(1'b0, 32'd0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        check("t1_valid", 32'(instr_valid), 32'd1);
        check("t1_i0", instr, 32'd0);
        check("t1_pc0", instr_pc, 32'd0);
        @(negedge clk);
        check("t1_i1", instr, 32'd1);
        check("t1_pc1", instr_pc, 32'd4);
        @(negedge clk);
        check("t1_i2", instr, 32'd2);
        check("t1_pc2", instr_pc, 32'd8);

        // Decode back-pressure: queue fills, requests stop, head held.
        tick();
        instr_ready = 1'b0;
        @(negedge clk);
        hold_pc    = instr_pc;
        hold_instr = instr;
        repeat (4) begin
            @(negedge clk);
            check("t2_hold_pc", instr_pc, hold_pc);
            check("t2_hold_instr", instr, hold_instr);
        end
        check("t2_req_stopped", 32'(imem_req), 32'd0);
        tick();
        instr_ready = 1'b1;
        repeat (6) tick();

        // Redirect with the queue's slots all committed and a response in flight.
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        tick();
        redirect    = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        check("t3_req", 32'(imem_req), 32'd1);
        check("t3_addr", imem_addr, 32'h40);
        @(negedge clk);
        @(negedge clk);
        check("t3_valid", 32'(instr_valid), 32'd1);
        check("t3_pc", instr_pc, 32'h40);
        check("t3_instr", instr, 32'h10);

        // Unaligned redirect target and address wrap.
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0043;
        tick();
        redirect    = 1'b0;
        @(negedge clk);
        check("t4_align_addr", imem_addr, 32'h40);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect    = 1'b0;
        @(negedge clk);
        check("t4_addr_fff8", imem_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        check("t4_addr_fffc", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        check("t4_wrap_addr", imem_addr, 32'h0);
        check("t4_wrap_req", 32'(imem_req), 32'd1);
        check("t4_pc_fff8", instr_pc, 32'hFFFF_FFF8);
        @(negedge clk);
        check("t4_pc_fffc", instr_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        check("t4_pc_0", instr_pc, 32'h0);
        check("t4_instr_0", instr, 32'h0);

        // Reset in the middle of streaming.
        repeat (3) tick();
        do_reset(1'b0, 32'd0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        check("t5_valid", 32'(instr_valid), 32'd1);
        check("t5_pc", instr_pc, RESET_PC);

        // Redirect during BOOT only moves the first fetch address.
        do_reset(1'b1, 32'h0000_0080);
        @(negedge clk);
        check("t8_boot_addr", imem_addr, 32'h80);
        @(negedge clk);
        @(negedge clk);
        check("t8_boot_pc", instr_pc, 32'h80);
        check("t8_boot_instr", instr, 32'h20);

        // Ten handshakes with a redirect in between.
        instr_ready = 1'b0;
        do_reset(1'b0, 32'd0);
        instr_ready = 1'b1;
        hs          = 0;
        redir_done  = 1'b0;
        for (int c = 0; c < 300 && hs < 10; c++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) hs++;
            tick();
            redirect = 1'b0;
            if (hs == 5 && !redir_done) begin
                redirect    = 1'b1;
                redirect_pc = 32'h0000_0200;
                redir_done  = 1'b1;
            end
            if (hs == 10) instr_ready = 1'b0;
        end
        check("t7_handshakes", 32'(hs), 32'd10);
        redirect = 1'b0;
        repeat (2) @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
        check("t7_fetch_count", fetch_count, 32'd10);
`endif

        // Randomized back-pressure and redirects.
        for (int i = 0; i < 1500; i++) begin
            tick();
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 29) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
        end
        tick();
        redirect    = 1'b0;
        instr_ready = 1'b1;
        repeat (8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter QDEPTH, default 2, meaning prefetch queue entries (legal values 1..4).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, asynchronous, active-high.
REQ-005 SHALL have port imem_req, output, 1, meaning instruction-memory read request this cycle.
REQ-006 SHALL have port imem_addr, output, 32, meaning byte address of the request, bits [1:0] always 0.
REQ-007 SHALL have port imem_rdata, input, 32, meaning read data, valid exactly one cycle after imem_req.
REQ-008 SHALL have ports redirect (input, 1) and redirect_pc (input, 32), meaning branch/jump target from execute.
REQ-009 SHALL have ports instr_valid (output, 1) and instr_ready (input, 1), meaning the valid/ready handshake to decode.
REQ-010 SHALL have ports instr (output, 32) and instr_pc (output, 32), meaning the queue-head instruction and its address.
REQ-011 SHALL have port fetch_count, output, 32, present only under FETCH_PERF_CNT_EN.

Function
REQ-012 SHALL use FSM states BOOT and RUN: BOOT lasts one cycle after reset release, then RUN; no request is issued in BOOT.
REQ-013 SHALL assert imem_req in RUN when (count + inflight - pop) < QDEPTH and redirect is low; pop = instr_valid & instr_ready.
REQ-014 SHALL drive imem_addr = fetch_pc, advancing fetch_pc by 4 on each issued request; wrap from 32'hFFFF_FFFC to 0.
REQ-015 SHALL push {pc, imem_rdata} into the queue one cycle after each issued, unsquashed request.
REQ-016 SHALL drive instr_valid = queue not empty, with instr/instr_pc from the queue head as registered state (no combinational path from imem_rdata).
REQ-017 SHALL hold instr and instr_pc stable while instr_valid & !instr_ready.
REQ-018 SHALL sustain one instruction per cycle with instr_ready held high when QDEPTH >= 2.
REQ-019 SHALL, on redirect: complete any same-cycle handshake, flush the queue, squash the in-flight response, and load fetch_pc with {redirect_pc[31:2], 2'b00}.
REQ-020 SHALL issue the redirect-target request the cycle after redirect; first redirected instr_valid arrives 3 cycles after redirect.
REQ-021 SHALL give redirect priority over push on simultaneous events; push and pop in the same cycle keep count unchanged.
REQ-022 SHALL never overflow: a push into a full queue is impossible by REQ-013 and SHALL be flagged by an assertion.
REQ-023 SHALL ignore redirect during BOOT except for loading fetch_pc.

Reset
REQ-024 SHALL, on rst, asynchronously set: state BOOT, fetch_pc RESET_PC, queue empty, inflight 0, imem_req 0, imem_addr RESET_PC, instr_valid 0, instr 0, instr_pc 0, fetch_count 0.
REQ-025 SHALL drop any in-flight response when rst asserts mid-operation; that data is never pushed.
REQ-026 SHALL present first instr_valid 3 cycles after rst deassertion (BOOT, request, response/push).

Configuration
REQ-027 SHALL, with FETCH_PERF_CNT_EN defined, provide fetch_count incremented on each completed handshake, wrapping at 2^32, unaffected by redirect.
REQ-028 SHALL, without FETCH_PERF_CNT_EN, omit the fetch_count port and counter logic entirely.

Structure
REQ-029 SHALL place XLEN=32, NOP=32'h0000_0013, the queue-entry typedef {pc, instr}, and the BOOT/RUN state enum in package fetch_pkg.
REQ-030 SHALL implement the queue as sub-module fetch_queue (parameterised depth, push, pop, flush, count, head outputs).

Verification
REQ-031 SHALL test reset release with RESET_PC=0 and ROM word i = i -> instr_valid at cycle 3, instr/instr_pc = 0/0, 1/4, 2/8 on consecutive cycles with instr_ready=1.
REQ-032 SHALL test instr_ready low for 5 cycles -> queue fills to QDEPTH, imem_req stops, instr/instr_pc held; after release no instruction lost or duplicated.
REQ-033 SHALL test redirect to 32'h40 while queue full and a request in flight -> queue flushed, in-flight word discarded, next delivered instr_pc = 32'h40.
REQ-034 SHALL test redirect_pc = 32'h43 -> request at 32'h40; and fetch_pc 32'hFFFF_FFFC -> next request at 0.
REQ-035 SHALL test rst asserted mid-stream -> all outputs at reset values immediately, first post-reset instr_pc = RESET_PC.
REQ-036 SHALL test FETCH_PERF_CNT_EN with 10 handshakes and one redirect -> fetch_count = 10.
